module_captura_operandos: RTL and testbench

MODULE_CAPTURA_OPERANDOS -- requirements
Module: module_captura_operandos

---
 rtl/module_captura_operandos.sv | 173 +++++++++++++++++
 tb/tb_module_captura_operandos.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_captura_operandos.sv
// Purpose: keypad operand capture; builds N_OPS packed BCD operands of N_DIGITS digits from debounced key presses.
// Latency: a press acts on the edge where key_valid is first sampled high; all outputs are registered (1 cycle).
// Backpressure: a finished set is held in DONE with out_valid high until out_ready is sampled high.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   key_code/key_valid debounced key (0-9 digit, 10 A next, 11 B finish, 12 C backspace, 13 D clear)
//   out_ready         consumer accepts the operand set offered in DONE
//   operands          packed BCD operands, operand i at [(i+1)*N_DIGITS*4-1 : i*N_DIGITS*4]
//   op_index          operand currently being entered
//   digit_count       digits entered in the current operand
//   busy/out_valid    state is not IDLE / complete set on offer
//   err               one-cycle pulse on a rejected key press
module module_captura_operandos #(
   parameter int N_OPS    = 2,
   parameter int N_DIGITS = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [3:0]                            key_code,
   input  logic                                  key_valid,
   input  logic                                  out_ready,
   output logic [N_OPS*N_DIGITS*4-1:0]           operands,
   output logic [((N_OPS > 1) ? $clog2(N_OPS) : 1)-1:0] op_index,
   output logic [$clog2(N_DIGITS+1)-1:0]         digit_count,
   output logic                                  busy,
   output logic                                  out_valid,
   output logic                                  err
);

   localparam int OP_W  = N_DIGITS * 4;
   localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
   localparam int CNT_W = $clog2(N_DIGITS + 1);

   localparam logic [IDX_W-1:0] LAST_OP = IDX_W'(N_OPS - 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_DIGITS);

   localparam logic [3:0] KEY_A = 4'd10;
   localparam logic [3:0] KEY_B = 4'd11;
   localparam logic [3:0] KEY_C = 4'd12;
   localparam logic [3:0] KEY_D = 4'd13;

   typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

   state_t                       state;
   logic [N_OPS-1:0][OP_W-1:0]   ops_q;
   logic                         key_valid_q;
   // Cleared by reset and set once key_valid is seen low, so a key held
   // through reset release cannot masquerade as a fresh press.
   logic                         armed;

   logic                         press;
   logic                         is_digit;
   logic [OP_W-1:0]              cur_op;
   logic [OP_W-1:0]              shl_op;
   logic [OP_W-1:0]              shr_op;

   assign press    = key_valid & ~key_valid_q & armed;
   assign is_digit = (key_code <= 4'd9);
   assign operands = ops_q;
   assign busy     = (state != IDLE);

   always_comb begin
      cur_op = ops_q[op_index];
      shl_op = (cur_op << 4) | OP_W'(key_code);
      shr_op = cur_op >> 4;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ops_q       <= '0;
         op_index    <= '0;
         digit_count <= '0;
         out_valid   <= 1'b0;
         err         <= 1'b0;
         key_valid_q <= 1'b0;
         armed       <= 1'b0;
      end else begin
         key_valid_q <= key_valid;
         armed       <= armed | ~key_valid;
         err         <= 1'b0;

         case (state)
            IDLE: begin
               if (press) begin
                  if (is_digit) begin
                     ops_q       <= '0;
                     ops_q[0]    <= OP_W'(key_code);
                     op_index    <= '0;
                     digit_count <= CNT_W'(1);
                     state       <= ENTRY;
                  end else if (key_code == KEY_D) begin
                     ops_q       <= '0;
                     op_index    <= '0;
                     digit_count <= '0;
                  end
                  // A, B, C and unused codes are silently ignored here.
               end
            end

            ENTRY: begin
               if (press) begin
                  if (is_digit) begin
                     if (digit_count < MAX_CNT) begin
                        ops_q[op_index] <= shl_op;
                        digit_count     <= digit_count + CNT_W'(1);
                     end else begin
                        err <= 1'b1;
                     end
                  end else begin
                     case (key_code)
                        KEY_A: begin
                           if ((digit_count != '0) && (op_index < LAST_OP)) begin
                              op_index    <= op_index + IDX_W'(1);
                              digit_count <= '0;
                           end else begin
                              err <= 1'b1;
                           end
                        end
                        KEY_B: begin
                           if ((op_index == LAST_OP) && (digit_count != '0)) begin
                              state     <= DONE;
                              out_valid <= 1'b1;
                           end else begin
                              err <= 1'b1;
                           end
                        end
                        KEY_C: begin
                           // Backspace stays within the current operand.
                           if (digit_count != '0) begin
                              ops_q[op_index] <= shr_op;
                              digit_count     <= digit_count - CNT_W'(1);
                           end else begin
                              err <= 1'b1;
                           end
                        end
                        KEY_D: begin
                           ops_q       <= '0;
                           op_index    <= '0;
                           digit_count <= '0;
                           state       <= IDLE;
                        end
                        default: err <= 1'b1;
                     endcase
                  end
               end
            end

            DONE: begin
               // The handshake wins: a press on the accepting edge is dropped.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end else if (press) begin
                  if (key_code == KEY_D) begin
                     ops_q       <= '0;
                     op_index    <= '0;
                     digit_count <= '0;
                     out_valid   <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_module_captura_operandos.sv
// Purpose: directed self-checking bench for module_captura_operandos (N_OPS=2, N_DIGITS=2).
// Latency: outputs sampled 1 time unit after the rising edge on which a press is first seen.
// Backpressure: out_ready driven directly to exercise hold-in-DONE and the accept handshake.
module tb_module_captura_operandos;

   logic        clk;
   logic        rst;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        out_ready;
   logic [15:0] operands;
   logic [0:0]  op_index;
   logic [1:0]  digit_count;
   logic        busy;
   logic        out_valid;
   logic        err;

   int checks = 0;
   int errors = 0;
   logic err_press;
   logic err_next;

   module_captura_operandos #(.N_OPS(2), .N_DIGITS(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .out_ready   (out_ready),
      .operands    (operands),
      .op_index    (op_index),
      .digit_count (digit_count),
      .busy        (busy),
      .out_valid   (out_valid),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Press and hold: outputs are sampled right after the edge that sees the press.
   task automatic press_key(input logic [3:0] c);
      @(negedge clk);
      key_code  = c;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      err_press = err;
   endtask

   task automatic release_key();
      @(negedge clk);
      key_valid = 1'b0;
      @(posedge clk);
      #1;
      err_next = err;
   endtask

   task automatic tap(input logic [3:0] c);
      press_key(c);
      release_key();
   endtask

   initial begin
      rst       = 1'b0;
      key_code  = 4'd0;
      key_valid = 1'b0;
      out_ready = 1'b0;
      err_press = 1'b0;
      err_next  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_operands",    operands,    16'h0000);
      check("rst_op_index",    op_index,    1'b0);
      check("rst_digit_count", digit_count, 2'd0);
      check("rst_busy",        busy,        1'b0);
      check("rst_out_valid",   out_valid,   1'b0);
      check("rst_err",         err,         1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Full transaction 4,2,A,0,7,B then handshake
      tap(4'd4);
      check("t1_busy_after_first", busy, 1'b1);
      tap(4'd2);
      check("t1_ops_42",  operands,    16'h0042);
      check("t1_cnt_2",   digit_count, 2'd2);
      tap(4'd10);
      check("t1_idx_1",   op_index,    1'b1);
      check("t1_cnt_0",   digit_count, 2'd0);
      tap(4'd0);
      check("t1_zero_digit_cnt", digit_count, 2'd1);
      check("t1_ops_0042",       operands,    16'h0042);
      tap(4'd7);
      check("t1_ops_0742", operands, 16'h0742);
      tap(4'd11);
      check("t1_out_valid", out_valid, 1'b1);
      check("t1_ops_done",  operands,  16'h0742);
      repeat (3) @(posedge clk);
      #1;
      check("t1_hold_valid", out_valid, 1'b1);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t1_accept_valid", out_valid, 1'b0);
      check("t1_accept_busy",  busy,      1'b0);
      check("t1_accept_ops",   operands,  16'h0742);
      @(negedge clk);
      out_ready = 1'b0;

      // Key held 20 cycles yields one digit; new digit in IDLE clears old operands
      press_key(4'd5);
      repeat (19) @(posedge clk);
      release_key();
      check("hold_cnt", digit_count, 2'd1);
      check("hold_ops", operands,    16'h0005);
      check("hold_idx", op_index,    1'b0);

      // D in ENTRY clears and returns to IDLE
      tap(4'd13);
      check("clr_ops",  operands, 16'h0000);
      check("clr_busy", busy,     1'b0);

      // Overflow digit: 1,2,3
      tap(4'd1);
      tap(4'd2);
      check("ovf_no_err_2", err_press, 1'b0);
      tap(4'd3);
      check("ovf_err_pulse", err_press, 1'b1);
      check("ovf_err_drops", err_next,  1'b0);
      check("ovf_ops",       operands,  16'h0012);
      check("ovf_cnt",       digit_count, 2'd2);

      // Backspace: D,9,8,C,6 -> 96; C on empty operand 1
      tap(4'd13);
      tap(4'd9);
      tap(4'd8);
      tap(4'd12);
      check("bs_ops_09", operands,    16'h0009);
      check("bs_cnt_1",  digit_count, 2'd1);
      tap(4'd6);
      check("bs_ops_96", operands,    16'h0096);
      tap(4'd10);
      tap(4'd12);
      check("bs_empty_err", err_press, 1'b1);
      check("bs_empty_idx", op_index,  1'b1);
      check("bs_empty_ops", operands,  16'h0096);
      tap(4'd10);
      check("a_empty_err", err_press, 1'b1);
      check("a_empty_idx", op_index,  1'b1);

      // B before last operand, unused code in ENTRY, then DONE behaviour
      tap(4'd13);
      tap(4'd1);
      tap(4'd11);
      check("b_early_err",   err_press, 1'b1);
      check("b_early_valid", out_valid, 1'b0);
      check("b_early_busy",  busy,      1'b1);
      tap(4'd14);
      check("code14_entry_err", err_press, 1'b1);
      tap(4'd10);
      tap(4'd2);
      tap(4'd11);
      check("d2_valid", out_valid, 1'b1);
      check("d2_ops",   operands,  16'h0201);
      tap(4'd5);
      check("done_digit_err",   err_press, 1'b1);
      check("done_digit_valid", out_valid, 1'b1);
      check("done_digit_ops",   operands,  16'h0201);
      tap(4'd13);
      check("done_d_valid", out_valid, 1'b0);
      check("done_d_ops",   operands,  16'h0000);
      check("done_d_busy",  busy,      1'b0);

      // IDLE ignores A and 15 without err
      tap(4'd10);
      check("idle_a_err",  err_press, 1'b0);
      check("idle_a_busy", busy,      1'b0);
      tap(4'd15);
      check("idle_15_err", err_press, 1'b0);

      // Press on the same edge as the accept handshake is ignored
      tap(4'd8);
      tap(4'd10);
      tap(4'd1);
      tap(4'd11);
      check("hs_pre_valid", out_valid, 1'b1);
      @(negedge clk);
      key_code  = 4'd3;
      key_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hs_press_err",   err,       1'b0);
      check("hs_press_valid", out_valid, 1'b0);
      check("hs_press_ops",   operands,  16'h0108);
      check("hs_press_busy",  busy,      1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      key_valid = 1'b0;
      @(posedge clk);

      // Reset mid-entry with key 3 held through reset release
      tap(4'd13);
      press_key(4'd3);
      check("rk_entry_cnt", digit_count, 2'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rk_async_ops",   operands,    16'h0000);
      check("rk_async_busy",  busy,        1'b0);
      check("rk_async_cnt",   digit_count, 2'd0);
      check("rk_async_valid", out_valid,   1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rk_held_cnt",  digit_count, 2'd0);
      check("rk_held_busy", busy,        1'b0);
      check("rk_held_ops",  operands,    16'h0000);
      release_key();
      check("rk_release_cnt", digit_count, 2'd0);
      tap(4'd3);
      check("rk_repress_cnt", digit_count, 2'd1);
      check("rk_repress_ops", operands,    16'h0003);
      check("rk_repress_busy", busy,       1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
